// File: rtl/mips_wb_arbiter_pkg.sv
// Shared definitions for the MIPS Wishbone arbiter: FSM state and grant
// encodings, the default watchdog limit and the watchdog width helper.
package mips_wb_arbiter_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    // Grant encodings as seen on arb_grant_o.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    // State values are chosen equal to the grant encodings so the grant
    // output is the state register itself.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } state_t;

    // Watchdog counter width: wide enough to hold the limit, never below 8.
    function automatic int wdog_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/mips_wb_arbiter_if.sv
// Bundle of the fetch port, data port and shared Wishbone bus signals.
// arb is the arbiter's view, master the CPU side, slave the shared bus slave.
interface mips_wb_arbiter_if;

    // Instruction-fetch port
    logic        i_cyc_i;
    logic        i_stb_i;
    logic [31:0] i_adr_i;
    logic [31:0] i_dat_o;
    logic        i_ack_o;
    logic        i_err_o;

    // Data port
    logic        d_cyc_i;
    logic        d_stb_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_adr_i;
    logic [31:0] d_dat_i;
    logic [31:0] d_dat_o;
    logic        d_ack_o;
    logic        d_err_o;

    // Shared bus
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    logic [1:0]  arb_grant_o;

    modport arb (
        input  i_cyc_i, i_stb_i, i_adr_i,
        output i_dat_o, i_ack_o, i_err_o,
        input  d_cyc_i, d_stb_i, d_we_i, d_sel_i, d_adr_i, d_dat_i,
        output d_dat_o, d_ack_o, d_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output arb_grant_o
    );

    modport master (
        output i_cyc_i, i_stb_i, i_adr_i,
        input  i_dat_o, i_ack_o, i_err_o,
        output d_cyc_i, d_stb_i, d_we_i, d_sel_i, d_adr_i, d_dat_i,
        input  d_dat_o, d_ack_o, d_err_o,
        input  arb_grant_o
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/mips_wb_watchdog.sv
// Strobe watchdog: counts consecutive cycles of an unanswered strobe and
// flags when the count reaches TIMEOUT. Any cycle without count_en clears it.
module mips_wb_watchdog
    import mips_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = wdog_width(TIMEOUT);

    logic [CNT_W-1:0] cnt_reg;

    // Count waiting cycles; ack, err, strobe low or grant release restart from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (count_en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end else begin
            cnt_reg <= '0;
        end
    end

    assign expired = (cnt_reg == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mips_wb_arbiter.sv
// Two-port (fetch/data) Wishbone arbiter onto a single shared bus.
// Grant is held until the owner drops cyc; hand-over needs no idle cycle.
// A strobe left unanswered for TIMEOUT cycles gets a one-cycle forced error.
module mips_wb_arbiter
    import mips_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = TIMEOUT_DEFAULT,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mips_wb_arbiter_if.arb     bus
);

    state_t     state_reg;
    logic [1:0] last_grant_reg;

    logic gnt_cyc;
    logic gnt_stb;
    logic release_req;
    logic expired;
    logic timeout_hit;
    logic wb_stb;
    logic count_en;
    logic pick_data;

    // Request lines of whichever port currently owns the bus.
    always_comb begin
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        case (state_reg)
            ST_GNT_I: begin
                gnt_cyc = bus.i_cyc_i;
                gnt_stb = bus.i_stb_i;
            end
            ST_GNT_D: begin
                gnt_cyc = bus.d_cyc_i;
                gnt_stb = bus.d_stb_i;
            end
            default: ;
        endcase
    end

    // Owner dropping cyc ends the grant at the coming edge.
    assign release_req = (state_reg != ST_IDLE) && !gnt_cyc;

    // A slave ack or err in the expiry cycle wins over the forced error.
    assign timeout_hit = expired && gnt_stb && !bus.wb_ack_i && !bus.wb_err_i;

    assign count_en = wb_stb && !bus.wb_ack_i && !bus.wb_err_i && !release_req;

    // Simultaneous request tie-break: alternate, or DATA_FIRST before any grant.
    assign pick_data = (last_grant_reg == GNT_I) ||
                       ((last_grant_reg == GNT_NONE) && DATA_FIRST);

    mips_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .expired  (expired)
    );

    // Arbitration FSM; the state doubles as the registered grant output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GNT_NONE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_cyc_i && bus.d_cyc_i) begin
                        if (pick_data) begin
                            state_reg      <= ST_GNT_D;
                            last_grant_reg <= GNT_D;
                        end else begin
                            state_reg      <= ST_GNT_I;
                            last_grant_reg <= GNT_I;
                        end
                    end else if (bus.d_cyc_i) begin
                        state_reg      <= ST_GNT_D;
                        last_grant_reg <= GNT_D;
                    end else if (bus.i_cyc_i) begin
                        state_reg      <= ST_GNT_I;
                        last_grant_reg <= GNT_I;
                    end
                end
                ST_GNT_I: begin
                    if (!bus.i_cyc_i) begin
                        if (bus.d_cyc_i) begin
                            state_reg      <= ST_GNT_D;
                            last_grant_reg <= GNT_D;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_GNT_D: begin
                    if (!bus.d_cyc_i) begin
                        if (bus.i_cyc_i) begin
                            state_reg      <= ST_GNT_I;
                            last_grant_reg <= GNT_I;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Bus mux and response routing: only the owner sees ack/err.
    always_comb begin
        bus.wb_cyc_o = 1'b0;
        wb_stb       = 1'b0;
        bus.wb_we_o  = 1'b0;
        bus.wb_sel_o = 4'h0;
        bus.wb_adr_o = 32'h0;
        bus.wb_dat_o = 32'h0;
        bus.i_ack_o  = 1'b0;
        bus.i_err_o  = 1'b0;
        bus.d_ack_o  = 1'b0;
        bus.d_err_o  = 1'b0;
        case (state_reg)
            ST_GNT_I: begin
                bus.wb_cyc_o = bus.i_cyc_i;
                wb_stb       = bus.i_stb_i && !timeout_hit;
                bus.wb_sel_o = 4'hF;
                bus.wb_adr_o = bus.i_adr_i;
                bus.i_ack_o  = bus.wb_ack_i;
                bus.i_err_o  = bus.wb_err_i || timeout_hit;
            end
            ST_GNT_D: begin
                bus.wb_cyc_o = bus.d_cyc_i;
                wb_stb       = bus.d_stb_i && !timeout_hit;
                bus.wb_we_o  = bus.d_we_i;
                bus.wb_sel_o = bus.d_sel_i;
                bus.wb_adr_o = bus.d_adr_i;
                bus.wb_dat_o = bus.d_dat_i;
                bus.d_ack_o  = bus.wb_ack_i;
                bus.d_err_o  = bus.wb_err_i || timeout_hit;
            end
            default: ;
        endcase
    end

    assign bus.wb_stb_o    = wb_stb;
    assign bus.i_dat_o     = bus.wb_dat_i;
    assign bus.d_dat_o     = bus.wb_dat_i;
    assign bus.arb_grant_o = state_reg;

endmodule

// File: tb/tb_mips_wb_arbiter.sv
// Bench for mips_wb_arbiter (TIMEOUT=4, DATA_FIRST=1). Responses seen on the
// port ack/err outputs are matched against a queue of expected responses.
module tb_mips_wb_arbiter;
    import mips_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        port;    // 0 fetch, 1 data
        logic        is_err;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    mips_wb_arbiter_if bus();

    mips_wb_arbiter #(
        .TIMEOUT    (4),
        .DATA_FIRST (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_cyc_i  = 1'b0; bus.i_stb_i = 1'b0; bus.i_adr_i = 32'h0;
        bus.d_cyc_i  = 1'b0; bus.d_stb_i = 1'b0; bus.d_we_i  = 1'b0;
        bus.d_sel_i  = 4'h0; bus.d_adr_i = 32'h0; bus.d_dat_i = 32'h0;
        bus.wb_dat_i = 32'h0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    endtask

    task automatic push_exp(input logic port, input logic is_err, input logic [31:0] data);
        exp_t e;
        e.port   = port;
        e.is_err = is_err;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // Response monitor: every ack/err on either port must match the queue head.
    always @(negedge clk) begin : resp_monitor
        logic        ack_v;
        logic        err_v;
        logic [31:0] dat_v;
        exp_t        e;
        for (int p = 0; p < 2; p++) begin
            ack_v = (p == 1) ? bus.d_ack_o : bus.i_ack_o;
            err_v = (p == 1) ? bus.d_err_o : bus.i_err_o;
            dat_v = (p == 1) ? bus.d_dat_o : bus.i_dat_o;
            if (ack_v || err_v) begin
                $display("resp t=%0t port=%s kind=%s data=%h", $time,
                         (p == 1) ? "D" : "I", err_v ? "err" : "ack", dat_v);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: port=%0d ack=%0b err=%0b, required no response",
                             p, ack_v, err_v);
                end else begin
                    e = exp_q.pop_front();
                    if (e.port !== p[0] || e.is_err !== err_v ||
                        (!err_v && e.data !== dat_v)) begin
                        errors++;
                        $display("FAIL resp_match: got port=%0d err=%0b data=%h, required port=%0d err=%0b data=%h",
                                 p, err_v, dat_v, e.port, e.is_err, e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) step();
        sample();
        checks++;
        if (bus.arb_grant_o !== GNT_NONE) begin
            errors++; $display("FAIL reset_grant: got %b required %b", bus.arb_grant_o, GNT_NONE);
        end
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got cyc/stb/we=%b required 000",
                               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o});
        end
        checks++;
        if ({bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o} !== 68'h0) begin
            errors++; $display("FAIL reset_bus: got sel=%h adr=%h dat=%h required zeros",
                               bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_fetch_only();
        step();
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1; bus.i_adr_i = 32'h0000_1000;
        sample();
        checks++;
        if (bus.arb_grant_o !== GNT_NONE) begin
            errors++; $display("FAIL fetch_c0_grant: got %b required 00", bus.arb_grant_o);
        end
        step(); sample();
        checks++;
        if (bus.arb_grant_o !== GNT_I) begin
            errors++; $display("FAIL fetch_c1_grant: got %b required 01", bus.arb_grant_o);
        end
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o} !==
            {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_1000}) begin
            errors++; $display("FAIL fetch_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h required 1 1 0 f 00001000",
                               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o);
        end
        step(); sample();
        step();
        bus.wb_dat_i = 32'hDEADBEEF; bus.wb_ack_i = 1'b1;
        push_exp(1'b0, 1'b0, 32'hDEADBEEF);
        sample();
        checks++;
        if ({bus.i_ack_o, bus.i_dat_o} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL fetch_c3_ack: got ack=%b dat=%h required 1 deadbeef",
                               bus.i_ack_o, bus.i_dat_o);
        end
        checks++;
        if (bus.d_ack_o !== 1'b0) begin
            errors++; $display("FAIL fetch_d_ack: got %b required 0", bus.d_ack_o);
        end
        step();
        bus.wb_ack_i = 1'b0; bus.i_cyc_i = 1'b0; bus.i_stb_i = 1'b0;
        step(); sample();
        checks++;
        if (bus.arb_grant_o !== GNT_NONE) begin
            errors++; $display("FAIL fetch_release: got %b required 00", bus.arb_grant_o);
        end
    endtask

    task automatic test_simultaneous();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1; bus.i_adr_i = 32'h0000_3000;
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1; bus.d_adr_i = 32'h0000_0200;
        step(); sample();
        checks++;
        if (bus.arb_grant_o !== GNT_D) begin
            errors++; $display("FAIL sim_first_data: got %b required 10", bus.arb_grant_o);
        end
        step();
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1111_1111;
        push_exp(1'b1, 1'b0, 32'h1111_1111);
        sample();
        checks++;
        if (bus.i_ack_o !== 1'b0) begin
            errors++; $display("FAIL sim_i_ack_blocked: got %b required 0", bus.i_ack_o);
        end
        step();
        bus.wb_ack_i = 1'b0; bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0;
        step(); sample();
        checks++;
        if (bus.arb_grant_o !== GNT_I) begin
            errors++; $display("FAIL sim_handoff: got %b required 01", bus.arb_grant_o);
        end
        step();
        bus.i_cyc_i = 1'b0; bus.i_stb_i = 1'b0;
        // Short data-only grant so that data becomes the last grant.
        step();
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1;
        step(); sample();
        checks++;
        if (bus.arb_grant_o !== GNT_D) begin
            errors++; $display("FAIL sim_data_only: got %b required 10", bus.arb_grant_o);
        end
        step();
        bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0;
        step();
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1;
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1;
        step(); sample();
        checks++;
        if (bus.arb_grant_o !== GNT_I) begin
            errors++; $display("FAIL sim_alternate_fetch: got %b required 01", bus.arb_grant_o);
        end
        step();
        clear_inputs();
        step(); step();
    endtask

    task automatic test_data_write();
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1; bus.d_we_i = 1'b1;
        bus.d_sel_i = 4'b0011; bus.d_adr_i = 32'h0000_0100; bus.d_dat_i = 32'hCAFE_F00D;
        step();
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1; bus.i_adr_i = 32'h0000_2000;
        sample();
        checks++;
        if (bus.arb_grant_o !== GNT_D) begin
            errors++; $display("FAIL write_grant: got %b required 10", bus.arb_grant_o);
        end
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o} !== 7'b111_0011) begin
            errors++; $display("FAIL write_ctrl: got cyc/stb/we/sel=%b required 1110011",
                               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o});
        end
        checks++;
        if ({bus.wb_adr_o, bus.wb_dat_o} !== {32'h0000_0100, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL write_adr_dat: got adr=%h dat=%h required 00000100 cafef00d",
                               bus.wb_adr_o, bus.wb_dat_o);
        end
        step(); sample();
        checks++;
        if ({bus.arb_grant_o, bus.i_ack_o} !== {GNT_D, 1'b0}) begin
            errors++; $display("FAIL write_no_preempt: got grant=%b i_ack=%b required 10 0",
                               bus.arb_grant_o, bus.i_ack_o);
        end
        step();
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h55AA_55AA;
        push_exp(1'b1, 1'b0, 32'h55AA_55AA);
        sample();
        step();
        bus.wb_ack_i = 1'b0;
        bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0; bus.d_we_i = 1'b0;
        sample();
        checks++;
        if (bus.arb_grant_o !== GNT_D) begin
            errors++; $display("FAIL write_release_cycle: got %b required 10", bus.arb_grant_o);
        end
        step(); sample();
        checks++;
        if ({bus.arb_grant_o, bus.wb_adr_o} !== {GNT_I, 32'h0000_2000}) begin
            errors++; $display("FAIL write_then_fetch: got grant=%b adr=%h required 01 00002000",
                               bus.arb_grant_o, bus.wb_adr_o);
        end
        step();
        clear_inputs();
        step(); step();
    endtask

    task automatic test_timeout();
        int err_cycle;
        err_cycle = 0;
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1; bus.d_adr_i = 32'h0000_0300;
        push_exp(1'b1, 1'b1, 32'h0);
        for (int k = 1; k <= 10 && err_cycle == 0; k++) begin
            step(); sample();
            if (bus.d_err_o === 1'b1) begin
                err_cycle = k;
                checks++;
                if ({bus.wb_stb_o, bus.arb_grant_o} !== {1'b0, GNT_D}) begin
                    errors++; $display("FAIL timeout_stb_forced: got stb=%b grant=%b required 0 10",
                                       bus.wb_stb_o, bus.arb_grant_o);
                end
            end
        end
        checks++;
        if (err_cycle != 5) begin
            errors++; $display("FAIL timeout_cycle: got granted cycle %0d required 5 (0 = none within bound)",
                               err_cycle);
        end
        step(); sample();
        checks++;
        if ({bus.d_err_o, bus.wb_stb_o, bus.arb_grant_o} !== {1'b0, 1'b1, GNT_D}) begin
            errors++; $display("FAIL timeout_single_pulse: got err=%b stb=%b grant=%b required 0 1 10",
                               bus.d_err_o, bus.wb_stb_o, bus.arb_grant_o);
        end
        step();
        bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0;
        step(); sample();
        checks++;
        if (bus.arb_grant_o !== GNT_NONE) begin
            errors++; $display("FAIL timeout_release: got %b required 00", bus.arb_grant_o);
        end
    endtask

    task automatic test_ack_at_timeout();
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1; bus.d_adr_i = 32'h0000_0400;
        repeat (4) step();
        step();
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0BAD_F00D;
        push_exp(1'b1, 1'b0, 32'h0BAD_F00D);
        sample();
        checks++;
        if ({bus.d_ack_o, bus.d_err_o, bus.wb_stb_o} !== 3'b101) begin
            errors++; $display("FAIL ack_at_timeout: got ack/err/stb=%b required 101",
                               {bus.d_ack_o, bus.d_err_o, bus.wb_stb_o});
        end
        step();
        bus.wb_ack_i = 1'b0; bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1; bus.d_adr_i = 32'h0000_0500;
        step(); sample();
        checks++;
        if (bus.arb_grant_o !== GNT_D) begin
            errors++; $display("FAIL rstmid_grant: got %b required 10", bus.arb_grant_o);
        end
        step();
        rst = 1'b1;
        sample();
        step();
        rst = 1'b0;
        bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0;
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h7777_7777;
        sample();
        checks++;
        if ({bus.arb_grant_o, bus.wb_cyc_o} !== {GNT_NONE, 1'b0}) begin
            errors++; $display("FAIL rstmid_idle: got grant=%b cyc=%b required 00 0",
                               bus.arb_grant_o, bus.wb_cyc_o);
        end
        checks++;
        if ({bus.d_ack_o, bus.d_err_o} !== 2'b00) begin
            errors++; $display("FAIL rstmid_late_ack: got ack/err=%b required 00",
                               {bus.d_ack_o, bus.d_err_o});
        end
        step();
        bus.wb_ack_i = 1'b0;
        sample();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_data_write();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL pending_responses: got %0d outstanding required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
